// File: rtl/heartbeat_pkg.sv
// Shared types and helpers for the heartbeat beacon: FSM states, default sync word,
// and the IEEE 802.3 Manchester half-bit encoder.
package heartbeat_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StParity,
    StGap
  } hb_state_e;

  localparam logic [7:0] DefaultSyncPattern = 8'hD5;

  // First half-bit carries the complement, second half-bit the bit itself.
  function automatic logic manchester_enc(input logic data_bit, input logic half);
    return half ? data_bit : ~data_bit;
  endfunction

endpackage

// File: rtl/heartbeat_beacon_delay.sv
// Inverter chain on the beacon output for analog delay characterisation; collapses
// to a plain wire when STAGES is zero or under cocotb simulation.
module inv_delay_line #(
  parameter int unsigned STAGES = 0
) (
  input  logic din,
  output logic dout
);

`ifdef COCOTB_SIM
  assign dout = din;
`else
  if (STAGES == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_chain
    logic [STAGES:0] tap;
    assign tap[0] = din;
    for (genvar i = 0; i < STAGES; i++) begin : inverter
      assign tap[i+1] = ~tap[i];
    end
    assign dout = tap[STAGES];
  end
`endif

endmodule

// File: rtl/heartbeat_beacon.sv
// Manchester-encoded liveness beacon: repeating frames of sync word, free-running
// counter and optional even parity, separated by a low idle gap.
module heartbeat_beacon
  import heartbeat_pkg::*;
#(
  parameter int unsigned           COUNTER_WIDTH   = 8,
  parameter int unsigned           SYNC_WIDTH      = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN    = SYNC_WIDTH'(DefaultSyncPattern),
  parameter bit                    PARITY_EN       = 1'b1,
  parameter int unsigned           HALF_BIT_CYCLES = 2,
  parameter int unsigned           GAP_BITS        = 4,
  parameter int unsigned           DELAY_STAGES    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic signal,
  output logic frame_start,
  output logic busy
);

  localparam int unsigned MaxLen0 = (SYNC_WIDTH > COUNTER_WIDTH) ? SYNC_WIDTH : COUNTER_WIDTH;
  localparam int unsigned MaxLen  = (MaxLen0 > GAP_BITS) ? MaxLen0 : GAP_BITS;
  localparam int unsigned IdxW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int unsigned DivW    = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(HALF_BIT_CYCLES - 1);

  if ((DELAY_STAGES % 2 != 0) || (HALF_BIT_CYCLES < 1) || (GAP_BITS < 1)) begin : g_param_check
    $error("heartbeat_beacon: DELAY_STAGES must be even, HALF_BIT_CYCLES and GAP_BITS >= 1");
  end

  hb_state_e              state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic                   half_q, half_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] latched_q, latched_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic                   signal_q, line_d;
  logic                   frame_start_q;
  logic                   start, enter_gap;
  logic                   sync_bit, data_bit;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    idx_d     = idx_q;
    latched_d = latched_q;
    counter_d = counter_q;
    start     = 1'b0;
    enter_gap = 1'b0;
    if (state_q == StIdle) begin
      start = en;
    end else if (div_q != DivLast) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d  = '0;
      half_d = ~half_q;
      // End of a bit-time: step the index or move to the next field.
      if (half_q) begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          case (state_q)
            StSync: begin
              state_d = StData;
              idx_d   = IdxW'(COUNTER_WIDTH - 1);
            end
            StData: begin
              if (PARITY_EN) state_d = StParity;
              else           enter_gap = 1'b1;
            end
            StParity: enter_gap = 1'b1;
            StGap: begin
              if (en) start = 1'b1;
              else    state_d = StIdle;
            end
            default: state_d = StIdle;
          endcase
        end
      end
    end
    if (enter_gap) begin
      state_d   = StGap;
      idx_d     = IdxW'(GAP_BITS - 1);
      counter_d = counter_q + 1'b1;
    end
    if (start) begin
      state_d   = StSync;
      idx_d     = IdxW'(SYNC_WIDTH - 1);
      latched_d = counter_q;
    end
  end

  // Line level is derived from next-state registers so the pin itself is a flop.
  always_comb begin
    sync_bit = (SYNC_PATTERN & (SYNC_WIDTH'(1) << idx_d)) != '0;
    data_bit = (latched_d & (COUNTER_WIDTH'(1) << idx_d)) != '0;
    case (state_d)
      StSync:   line_d = manchester_enc(sync_bit, half_d);
      StData:   line_d = manchester_enc(data_bit, half_d);
      StParity: line_d = manchester_enc(^latched_d, half_d);
      default:  line_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      half_q        <= 1'b0;
      idx_q         <= '0;
      latched_q     <= '0;
      counter_q     <= '0;
      signal_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      half_q        <= half_d;
      idx_q         <= idx_d;
      latched_q     <= latched_d;
      counter_q     <= counter_d;
      signal_q      <= line_d;
      frame_start_q <= start;
    end
  end

  assign frame_start = frame_start_q;
  assign busy        = (state_q != StIdle);

  inv_delay_line #(
    .STAGES(DELAY_STAGES)
  ) u_delay (
    .din (signal_q),
    .dout(signal)
  );

endmodule
